// File: rtl/seven_sched.sv
// Round-robin scheduler that time-shares one 4-digit 7-segment display between
// four req/ack requesters, holding each granted value for a minimum time.
module seven_sched #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] data,
  input  logic        blank,
  output logic [3:0]  ack,
  output logic [15:0] disp_val,
  output logic        disp_en,
  output logic [1:0]  disp_src,
  output logic        busy
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]  ptr_reg, ptr_next;
  logic [3:0]  ack_reg, ack_next;
  logic [15:0] val_reg, val_next;
  logic [1:0]  src_reg, src_next;
  logic        en_reg, en_next;

  logic [15:0] lane [4];
  logic [1:0]  cand [4];
  logic        found;
  logic [1:0]  win;

  // cand[k] is the requester examined k-th, starting at the rr pointer
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = data[16*gi +: 16];
      assign cand[gi] = ptr_reg + 2'(gi);
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    win   = ptr_reg;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[cand[k]]) begin
        found = 1'b1;
        win   = cand[k];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    ack_next   = 4'b0000;
    val_next   = val_reg;
    src_next   = src_reg;
    en_next    = en_reg;
    if (blank) begin
      // blank wins over any grant and drops a hold in progress
      state_next = IDLE;
      cnt_next   = '0;
      en_next    = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_next    = HOLD;
            cnt_next      = CNT_LOAD;
            ptr_next      = win + 2'd1;
            ack_next[win] = 1'b1;
            val_next      = lane[win];
            src_next      = win;
            en_next       = 1'b1;
          end
        end
        HOLD: begin
          if (cnt_reg == '0) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= 2'd0;
      ack_reg   <= 4'b0000;
      val_reg   <= 16'h0000;
      src_reg   <= 2'd0;
      en_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      ack_reg   <= ack_next;
      val_reg   <= val_next;
      src_reg   <= src_next;
      en_reg    <= en_next;
    end
  end

  assign ack      = ack_reg;
  assign disp_val = val_reg;
  assign disp_en  = en_reg;
  assign disp_src = src_reg;
  assign busy     = (state_reg == HOLD);

endmodule

// File: tb/tb_seven_sched.sv
// Directed testbench for seven_sched with HOLD_CYCLES=4; one task per scenario,
// each comparing outputs against hand-computed values.
module tb_seven_sched;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] data;
  logic        blank;
  logic [3:0]  ack;
  logic [15:0] disp_val;
  logic        disp_en;
  logic [1:0]  disp_src;
  logic        busy;

  int checks;
  int failures;

  seven_sched #(.HOLD_CYCLES(HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .blank    (blank),
    .ack      (ack),
    .disp_val (disp_val),
    .disp_en  (disp_en),
    .disp_src (disp_src),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s wait_idle: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; blank = 1'b0;
    data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    #1;
    checks++;
    if ({ack, disp_val, disp_en, disp_src, busy} !== 24'h0) begin
      failures++;
      $display("FAIL reset_init: ack=%b val=%h en=%b src=%0d busy=%b, required all 0",
               ack, disp_val, disp_en, disp_src, busy);
    end
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if ({ack, disp_en, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_release: ack=%b en=%b busy=%b, required 0", ack, disp_en, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    data[47:32] = 16'hBEEF;
    req = 4'b0100;
    step();
    req = 4'b0000;
    checks++;
    if (ack !== 4'b0100 || disp_val !== 16'hBEEF || disp_src !== 2'd2 ||
        disp_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: ack=%b val=%h src=%0d en=%b busy=%b, required 0100 BEEF 2 1 1",
               ack, disp_val, disp_src, disp_en, busy);
    end
    for (int c = 1; c < HOLD; c++) begin
      step();
      checks++;
      if (busy !== 1'b1 || ack !== 4'b0000) begin
        failures++;
        $display("FAIL single_hold c%0d: busy=%b ack=%b, required 1 0000", c, busy, ack);
      end
    end
    step();
    checks++;
    if (busy !== 1'b0 || disp_en !== 1'b1 || disp_val !== 16'hBEEF) begin
      failures++;
      $display("FAIL single_end: busy=%b en=%b val=%h, required 0 1 BEEF", busy, disp_en, disp_val);
    end
    $display("test_single done");
  endtask

  task automatic test_mid_reset();
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({ack, disp_val, disp_en, disp_src, busy} !== 24'h0) begin
      failures++;
      $display("FAIL midreset_async: ack=%b val=%h en=%b src=%0d busy=%b, required all 0",
               ack, disp_val, disp_en, disp_src, busy);
    end
    step();
    checks++;
    if ({ack, disp_val, disp_en, busy} !== 22'h0) begin
      failures++;
      $display("FAIL midreset_held: ack=%b val=%h en=%b busy=%b, required all 0",
               ack, disp_val, disp_en, busy);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({ack, disp_val, disp_en, busy} !== 22'h0) begin
      failures++;
      $display("FAIL midreset_after: ack=%b val=%h en=%b busy=%b, required all 0",
               ack, disp_val, disp_en, busy);
    end
    $display("test_mid_reset done");
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [15:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    int cyc;
    int last;
    data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req = 4'b1111;
    cyc = 0;
    last = -1;
    for (int g = 0; g < 5; g++) begin
      int n;
      n = 0;
      do begin
        step();
        cyc++;
        n++;
      end while (ack === 4'b0000 && n < 12);
      checks++;
      if (ack !== (4'b0001 << order[g]) || disp_val !== vals[order[g]] ||
          disp_src !== 2'(order[g])) begin
        failures++;
        $display("FAIL rr_grant%0d: ack=%b val=%h src=%0d, required ack bit %0d val %h",
                 g, ack, disp_val, disp_src, order[g], vals[order[g]]);
      end
      if (last >= 0) begin
        checks++;
        if (cyc - last !== HOLD + 1) begin
          failures++;
          $display("FAIL rr_spacing%0d: spacing=%0d, required %0d", g, cyc - last, HOLD + 1);
        end
      end
      last = cyc;
    end
    req = 4'b0000;
    step();
    wait_idle("rr");
    $display("test_round_robin done");
  endtask

  task automatic test_mid_hold_req();
    int n;
    req = 4'b0001;
    step();
    req = 4'b0000;
    checks++;
    if (ack !== 4'b0001) begin
      failures++;
      $display("FAIL midhold_grant0: ack=%b, required 0001", ack);
    end
    step();
    req = 4'b0010;
    n = 0;
    while (busy === 1'b1 && n < 12) begin
      checks++;
      if (ack !== 4'b0000) begin
        failures++;
        $display("FAIL midhold_noack: ack=%b during hold, required 0000", ack);
      end
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0000) begin
      failures++;
      $display("FAIL midhold_release: busy=%b ack=%b, required 0 0000", busy, ack);
    end
    step();
    req = 4'b0000;
    checks++;
    if (ack !== 4'b0010 || disp_val !== 16'h2222) begin
      failures++;
      $display("FAIL midhold_grant1: ack=%b val=%h, required 0010 2222", ack, disp_val);
    end
    step();
    wait_idle("midhold");
    $display("test_mid_hold_req done");
  endtask

  task automatic test_blank();
    data[15:0] = 16'hA5A5;
    req = 4'b0001;
    step();
    req = 4'b1000;
    step();
    blank = 1'b1;
    step();
    checks++;
    if (disp_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 ||
        disp_val !== 16'hA5A5 || disp_src !== 2'd0) begin
      failures++;
      $display("FAIL blank_hold: en=%b ack=%b busy=%b val=%h src=%0d, required 0 0000 0 A5A5 0",
               disp_en, ack, busy, disp_val, disp_src);
    end
    step();
    checks++;
    if (disp_en !== 1'b0 || ack !== 4'b0000) begin
      failures++;
      $display("FAIL blank_priority: en=%b ack=%b, required 0 0000", disp_en, ack);
    end
    blank = 1'b0;
    step();
    req = 4'b0000;
    checks++;
    if (ack !== 4'b1000 || disp_en !== 1'b1 || disp_val !== 16'h4444 || disp_src !== 2'd3) begin
      failures++;
      $display("FAIL blank_regrant: ack=%b en=%b val=%h src=%0d, required 1000 1 4444 3",
               ack, disp_en, disp_val, disp_src);
    end
    step();
    wait_idle("blank");
    $display("test_blank done");
  endtask

  task automatic test_withdraw();
    int n;
    req = 4'b0001;
    step();
    req = 4'b1101;
    n = 0;
    while (busy === 1'b1 && n < 12) begin
      step();
      n++;
    end
    req = 4'b1001;
    step();
    req = 4'b0000;
    checks++;
    if (ack !== 4'b1000 || disp_src !== 2'd3) begin
      failures++;
      $display("FAIL withdraw_winner: ack=%b src=%0d, required 1000 3", ack, disp_src);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (ack[2] !== 1'b0) begin
        failures++;
        $display("FAIL withdraw_noack2 c%0d: ack=%b, required bit2 0", c, ack);
      end
    end
    $display("test_withdraw done");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_mid_reset();
    test_round_robin();
    test_mid_hold_req();
    test_blank();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
